// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the LED pattern sequencer.
//   state_e   - per-channel FSM state encoding (IDLE, RUN, DONE)
//   ch_w()    - width of a channel index for a given channel count (min 1)
//   PWM_W     - width of the shared PWM phase counter (LED_PWM_EN builds)
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int PWM_W = 4;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: configuration request bundle for led_pattern_seq.
//   cfg_valid/cfg_ready - handshake, transfer when both high
//   cfg_chan            - target channel index
//   cfg_pattern         - new pattern, bit 0 emitted first
//   cfg_div             - new step divider (step period = div+1 cycles)
//   cfg_oneshot         - 1 = stop after one pass, 0 = loop
//   cfg_duty            - PWM duty 0..16 (only when LED_PWM_EN is defined)
// Modports: master drives the request, slave (the sequencer) returns ready.
interface led_pattern_seq_if #(
  parameter int CHANNELS = 1,
  parameter int PAT_LEN  = 16,
  parameter int DIV_W    = 24
);
  localparam int CH_W = led_seq_pkg::ch_w(CHANNELS);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_chan;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic [DIV_W-1:0]   cfg_div;
  logic               cfg_oneshot;
`ifdef LED_PWM_EN
  logic [led_seq_pkg::PWM_W:0] cfg_duty;
`endif

  modport master (
    output cfg_valid, cfg_chan, cfg_pattern, cfg_div, cfg_oneshot,
`ifdef LED_PWM_EN
    output cfg_duty,
`endif
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_pattern, cfg_div, cfg_oneshot,
`ifdef LED_PWM_EN
    input  cfg_duty,
`endif
    output cfg_ready
  );

endinterface

// File: rtl/led_seq_chan.sv
// led_seq_chan: one LED channel - FSM, step prescaler, pattern index,
// active and shadow configuration registers and the registered LED drive.
// Ports:
//   CLK, RST          - clock, asynchronous active-high reset
//   wr_en             - configuration accepted for this channel this cycle
//   wr_pattern/div/oneshot (+ wr_duty, pwm_cnt with LED_PWM_EN)
//   start, stop       - control pulses, stop dominates
//   led, busy, done   - LED drive, RUN indicator, one-shot completion pulse
//   pending           - shadow holds a config not yet applied
// Optional feature macro: LED_PWM_EN (duty register and PWM gating).
module led_seq_chan
  import led_seq_pkg::*;
#(
  parameter int                 PAT_LEN       = 16,
  parameter int                 DIV_W         = 24,
  parameter logic [DIV_W-1:0]   DEF_DIV       = DIV_W'(2097151),
  parameter logic [PAT_LEN-1:0] RESET_PATTERN = PAT_LEN'(16'h00FF),
  parameter bit                 AUTOSTART     = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [PAT_LEN-1:0] wr_pattern,
  input  logic [DIV_W-1:0]   wr_div,
  input  logic               wr_oneshot,
`ifdef LED_PWM_EN
  input  logic [PWM_W:0]     wr_duty,
  input  logic [PWM_W-1:0]   pwm_cnt,
`endif
  input  logic               start,
  input  logic               stop,
  output logic               led,
  output logic               busy,
  output logic               done,
  output logic               pending
);

  localparam int               IDX_W   = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(PAT_LEN - 1);
  localparam logic [1:0]       S_IDLE  = ST_IDLE;
  localparam logic [1:0]       S_RUN   = ST_RUN;
  localparam logic [1:0]       S_DONE  = ST_DONE;
  localparam logic [1:0]       S_RESET = AUTOSTART ? S_RUN : S_IDLE;

  typedef struct packed {
    logic [PAT_LEN-1:0] pattern;
    logic [DIV_W-1:0]   div;
    logic               oneshot;
`ifdef LED_PWM_EN
    logic [PWM_W:0]     duty;
`endif
  } cfg_t;

  cfg_t             wr_c;
  cfg_t             act_q, act_d, sh_q, sh_d;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             led_q, led_d;
  logic             done_q, done_d;
  logic             tick, oneshot_eff, gate;

  assign wr_c.pattern = wr_pattern;
  assign wr_c.div     = wr_div;
  assign wr_c.oneshot = wr_oneshot;
`ifdef LED_PWM_EN
  assign wr_c.duty    = wr_duty;
  assign gate         = ({1'b0, pwm_cnt} < act_q.duty);
`else
  assign gate         = 1'b1;
`endif

  assign tick = (state_q == S_RUN) && (presc_q == act_q.div);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    idx_d       = idx_q;
    act_d       = act_q;
    sh_d        = sh_q;
    pend_d      = pend_q;
    done_d      = 1'b0;
    oneshot_eff = act_q.oneshot;

    // A running channel must not change mid-pattern, so writes go to the shadow.
    if (wr_en) begin
      if (state_q == S_RUN) begin
        sh_d   = wr_c;
        pend_d = 1'b1;
      end else begin
        act_d = wr_c;
      end
    end

    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_RUN;
      idx_d   = '0;
      presc_d = '0;
      // A config arriving with the start is the newest; otherwise drain the shadow.
      if (wr_en) begin
        act_d  = wr_c;
        pend_d = 1'b0;
      end else if (pend_q) begin
        act_d  = sh_q;
        pend_d = 1'b0;
      end
    end else if (state_q == S_RUN) begin
      if (tick) begin
        presc_d = '0;
        if (idx_q == LAST) begin
          idx_d = '0;
          // ready is low while pending, so wr_en cannot collide with this copy.
          if (pend_q) begin
            act_d       = sh_q;
            pend_d      = 1'b0;
            oneshot_eff = sh_q.oneshot;
          end
          if (oneshot_eff) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end

    led_d = (state_q == S_RUN) && act_q.pattern[idx_q] && gate;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= S_RESET;
      presc_q         <= '0;
      idx_q           <= '0;
      pend_q          <= 1'b0;
      led_q           <= 1'b0;
      done_q          <= 1'b0;
      act_q.pattern   <= RESET_PATTERN;
      act_q.div       <= DEF_DIV;
      act_q.oneshot   <= 1'b0;
`ifdef LED_PWM_EN
      act_q.duty      <= (PWM_W+1)'(16);
`endif
      sh_q            <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      done_q  <= done_d;
      act_q   <= act_d;
      sh_q    <= sh_d;
    end
  end

  assign led     = led_q;
  assign done    = done_q;
  assign busy    = (state_q == S_RUN);
  assign pending = pend_q;

endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: CHANNELS independent LED pattern sequencers with a shared
// configuration port, per-channel start/stop and glitch-free pattern updates.
// Ports:
//   CLK, RST  - clock, asynchronous active-high reset
//   cfg       - led_pattern_seq_if.slave configuration request
//   start     - per-channel start/restart pulse
//   stop      - per-channel stop pulse (wins over start)
//   led       - registered LED drive
//   busy      - channel in RUN
//   done      - one-cycle pulse at one-shot completion
// Optional feature macro: LED_PWM_EN (cfg_duty input, shared PWM counter).
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int                 CHANNELS      = 1,
  parameter int                 PAT_LEN       = 16,
  parameter int                 DIV_W         = 24,
  parameter logic [DIV_W-1:0]   DEF_DIV       = DIV_W'(2097151),
  parameter logic [PAT_LEN-1:0] RESET_PATTERN = PAT_LEN'(16'h00FF),
  parameter bit                 AUTOSTART     = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  led_pattern_seq_if.slave    cfg,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  localparam int CH_W = ch_w(CHANNELS);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] wr_en;
  logic                ready;

  // Out-of-range channel numbers match no channel: accepted and dropped.
  always_comb begin
    ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((cfg.cfg_chan == CH_W'(c)) && busy[c] && pend[c]) ready = 1'b0;
    end
    wr_en = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_en[c] = cfg.cfg_valid && ready && (cfg.cfg_chan == CH_W'(c));
    end
  end

  assign cfg.cfg_ready = ready;

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    led_seq_chan #(
      .PAT_LEN       (PAT_LEN),
      .DIV_W         (DIV_W),
      .DEF_DIV       (DEF_DIV),
      .RESET_PATTERN (RESET_PATTERN),
      .AUTOSTART     (AUTOSTART)
    ) u_chan (
      .CLK        (CLK),
      .RST        (RST),
      .wr_en      (wr_en[c]),
      .wr_pattern (cfg.cfg_pattern),
      .wr_div     (cfg.cfg_div),
      .wr_oneshot (cfg.cfg_oneshot),
`ifdef LED_PWM_EN
      .wr_duty    (cfg.cfg_duty),
      .pwm_cnt    (pwm_cnt_q),
`endif
      .start      (start[c]),
      .stop       (stop[c]),
      .led        (led[c]),
      .busy       (busy[c]),
      .done       (done[c]),
      .pending    (pend[c])
    );
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed bench for led_pattern_seq with CHANNELS=3,
// PAT_LEN=16, DEF_DIV=3, RESET_PATTERN=16'h00FF, AUTOSTART=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pattern_seq;

  localparam int CHANNELS = 3;
  localparam int PAT_LEN  = 16;
  localparam int DIV_W    = 24;

  logic                CLK = 1'b0;
  logic                RST;
  logic [CHANNELS-1:0] start, stop, led, busy, done;

  int checks = 0;
  int errors = 0;

  logic [15:0] pa5 = 16'hA5A5;
  logic [15:0] p1  = 16'h000F;
  logic [15:0] p2  = 16'h5B3C;
  logic [15:0] p3  = 16'hFFFF;

  led_pattern_seq_if #(.CHANNELS(CHANNELS), .PAT_LEN(PAT_LEN), .DIV_W(DIV_W)) cfg_if ();

  led_pattern_seq #(
    .CHANNELS      (CHANNELS),
    .PAT_LEN       (PAT_LEN),
    .DIV_W         (DIV_W),
    .DEF_DIV       (24'd3),
    .RESET_PATTERN (16'h00FF),
    .AUTOSTART     (1'b1)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .cfg   (cfg_if),
    .start (start),
    .stop  (stop),
    .led   (led),
    .busy  (busy),
    .done  (done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] ch, input logic [15:0] pat,
                         input logic [23:0] dv, input logic os);
    cfg_if.cfg_chan    = ch;
    cfg_if.cfg_pattern = pat;
    cfg_if.cfg_div     = dv;
    cfg_if.cfg_oneshot = os;
  endtask

  // After reset release: 00FF at 4 cycles per step on every channel.
  task automatic check_default_seq();
    for (int k = 1; k <= 65; k++) begin
      @(negedge CLK);
      chk("default_led", led, (k <= 32 || k == 65) ? 3'b111 : 3'b000);
      chk("default_done", done, 3'b000);
    end
    chk("default_busy", busy, 3'b111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int cnt;
    RST = 1'b1;
    start = '0;
    stop  = '0;
    cfg_if.cfg_valid = 1'b0;
    set_cfg(2'd0, 16'h0, 24'd0, 1'b0);
`ifdef LED_PWM_EN
    cfg_if.cfg_duty = 5'd16;
`endif
    repeat (3) @(negedge CLK);
    chk("rst_led", led, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_busy", busy, 3'b111);
    chk("rst_ready", cfg_if.cfg_ready, 1'b1);

    RST = 1'b0;
    check_default_seq();

    // One-shot A5A5, configured together with the start while ch0 is IDLE.
    stop = 3'b001;
    @(negedge CLK);
    stop = 3'b000;
    chk("stop_busy", busy, 3'b110);
    set_cfg(2'd0, 16'hA5A5, 24'd0, 1'b1);
    cfg_if.cfg_valid = 1'b1;
    start = 3'b001;
    #1 chk("ready_idle", cfg_if.cfg_ready, 1'b1);
    @(negedge CLK);
    cfg_if.cfg_valid = 1'b0;
    start = 3'b000;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk("oneshot_led", led[0], pa5[i]);
      chk("oneshot_done", done[0], (i == 15) ? 1'b1 : 1'b0);
    end
    @(negedge CLK);
    chk("oneshot_end_led", led[0], 1'b0);
    chk("oneshot_end_done", done[0], 1'b0);
    chk("oneshot_end_busy", busy[0], 1'b0);

    // Loop 000F, then shadow-load 5B3C at idx 5; applies at the wrap.
    set_cfg(2'd0, p1, 24'd0, 1'b0);
    cfg_if.cfg_valid = 1'b1;
    start = 3'b001;
    @(negedge CLK);
    cfg_if.cfg_valid = 1'b0;
    start = 3'b000;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      chk("shadow_led", led[0], (i < 16) ? p1[i] : p2[i-16]);
      if (i == 4) begin
        chk("shadow_ready_free", cfg_if.cfg_ready, 1'b1);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_pattern = p2;
      end else if (i >= 5 && i <= 14) begin
        chk("shadow_ready_busy", cfg_if.cfg_ready, 1'b0);
        cfg_if.cfg_pattern = p3;
        if (i == 14) cfg_if.cfg_valid = 1'b0;
      end else if (i == 15) begin
        chk("shadow_ready_wrap", cfg_if.cfg_ready, 1'b1);
      end
    end

    // stop+start on ch1 together, plus a write to nonexistent channel 3.
    stop  = 3'b010;
    start = 3'b010;
    set_cfg(2'd3, p3, 24'd0, 1'b1);
    cfg_if.cfg_valid = 1'b1;
    #1 chk("ready_out_of_range", cfg_if.cfg_ready, 1'b1);
    j = 32;
    @(negedge CLK);
    chk("stopstart_led0", led[0], p2[j % 16]);
    stop  = 3'b000;
    start = 3'b000;
    cfg_if.cfg_valid = 1'b0;
    chk("stopstart_busy", busy, 3'b101);
    for (j = 33; j <= 56; j++) begin
      @(negedge CLK);
      chk("after_stop_led0", led[0], p2[j % 16]);
      chk("after_stop_led1", led[1], 1'b0);
    end
    chk("after_stop_busy", busy, 3'b101);

    // ch0 now at idx 9 with led high; asynchronous reset mid-cycle.
    #2 RST = 1'b1;
    #1;
    chk("async_rst_led", led, 3'b000);
    chk("async_rst_done", done, 3'b000);
    chk("async_rst_busy", busy, 3'b111);
    @(negedge CLK);
    RST = 1'b0;
    check_default_seq();

`ifdef LED_PWM_EN
    stop = 3'b001;
    @(negedge CLK);
    stop = 3'b000;
    set_cfg(2'd0, 16'hFFFF, 24'd0, 1'b0);
    cfg_if.cfg_duty  = 5'd4;
    cfg_if.cfg_valid = 1'b1;
    start = 3'b001;
    @(negedge CLK);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_duty  = 5'd16;
    start = 3'b000;
    repeat (2) @(negedge CLK);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      cnt += int'(led[0]);
    end
    chk("pwm_high_count", cnt, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Parametrised successor to the single hard-wired board blinker.
- Drives CHANNELS LED outputs, each stepping through its own runtime-loadable PAT_LEN-bit pattern at a programmable step rate.
- Per-channel loop or one-shot mode, start/stop control, and a shadowed config path so patterns can change glitch-free at pattern wrap.
- Instantiated in the board top; its outputs drive the user LED and any status LEDs.

Parameters:
CHANNELS, 1, number of independent LED channels (1..16)
PAT_LEN, 16, pattern length in bits (2..64)
DIV_W, 24, width of step-rate divider
DEF_DIV, 2097151, reset divider value; step period = div+1 CLK cycles (~7.6 Hz at 16 MHz)
RESET_PATTERN, 16'h00FF, reset pattern for every channel (PAT_LEN bits)
AUTOSTART, 1, if 1, all channels enter RUN (loop mode) on reset release

Ports:
CLK  in  1  system clock (16 MHz)
RST  in  1  reset, asynchronous, active-high
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when valid&&ready
cfg_chan  in  CH_W=max(1,clog2(CHANNELS))  target channel
cfg_pattern  in  PAT_LEN  new pattern, bit 0 emitted first
cfg_div  in  DIV_W  new divider
cfg_oneshot  in  1  1 = one-shot, 0 = loop
start  in  CHANNELS  per-channel start/restart pulse
stop  in  CHANNELS  per-channel stop pulse
led  out  CHANNELS  LED drive, registered
busy  out  CHANNELS  channel in RUN
done  out  CHANNELS  1-cycle pulse at one-shot completion

Behaviour:
- Reset values:
  - led = 0, done = 0, prescaler = 0, idx = 0, pending = 0.
  - pattern = RESET_PATTERN, div = DEF_DIV, oneshot = 0.
  - state = RUN if AUTOSTART, else IDLE.
  - busy follows state.
- Per-channel FSM, states IDLE, RUN, DONE:
  - IDLE/DONE + start -> RUN: idx = 0, prescaler = 0.
  - RUN + start -> restart (idx = 0, prescaler = 0).
  - Any state + stop -> IDLE. stop wins over a simultaneous start.
- Step timing in RUN:
  - Prescaler counts 0..div; at prescaler==div it issues a tick and returns to 0.
  - Each tick: idx = idx+1, wrapping PAT_LEN-1 -> 0.
  - div = 0 gives a tick every cycle.
- Wrap event: tick at idx==PAT_LEN-1.
  - If pending: copy shadow into active regs, clear pending.
  - Then, if the active oneshot (post-copy) = 1: state -> DONE, done pulses one cycle, idx = 0.
- led[c] is registered: pattern[idx] while RUN, 0 in IDLE/DONE. One cycle of latency from an idx change to led.
- Config path:
  - cfg_ready = 0 only when the target channel is RUN with pending = 1.
  - Target channel not in RUN: accept writes active regs directly next cycle.
  - Target channel in RUN: accept writes shadow regs and sets pending.
  - cfg_chan >= CHANNELS: accepted (ready=1) and discarded.
- Start in the same cycle as a config accept to the same non-running channel: the new config is used from idx 0.
- A pending shadow is also applied on start/restart. stop leaves pending intact.
- Async RST mid-run: all state returns to reset values immediately; led = 0 while RST is high.

Optional Feature:
- LED_PWM_EN defined:
  - Adds input cfg_duty [4:0], latched and shadowed alongside the pattern; reset value 16.
  - A shared 4-bit free-running pwm_cnt (reset 0) gates output: led[c] = pattern[idx] && (pwm_cnt < duty).
  - duty 0 = off; duty >= 16 = full on.
- Not defined: no cfg_duty port; led = pattern[idx] ungated.

Decomposition:
- Package led_seq_pkg:
  - state enum (IDLE, RUN, DONE).
  - clog2-based CH_W helper.
  - PWM_W = 4 constant.
- Sub-module led_seq_chan holds one channel's FSM, prescaler, active/shadow regs and led register. The top generates CHANNELS instances plus the cfg decode/ready mux and the shared pwm_cnt.

Test Plan:
- Reset defaults, CHANNELS=1, DEF_DIV=3, AUTOSTART=1 -> led sequence 1 for 8 steps, then 0 for 8 steps, each step 4 cycles; busy=1.
- Loop to one-shot in IDLE: write pattern 16'hA5A5, div=0, oneshot=1, then start -> led = 1,0,1,0,0,1,0,1,... LSB-first over 16 cycles; done pulses once; state DONE, led=0.
- Shadow update in RUN: accept cfg at idx 5 -> old pattern continues to idx 15, new pattern from next idx 0; a second cfg_valid sees cfg_ready=0 until the wrap.
- Simultaneous stop+start on ch1 with CHANNELS=4 -> ch1 IDLE, led[1]=0; channels 0, 2, 3 unaffected.
- Assert RST at idx 9 mid-run -> led=0 and done=0 immediately; after release, pattern restarts at idx 0 with RESET_PATTERN and DEF_DIV.
- LED_PWM_EN, duty=4, pattern all-ones -> led high exactly 4 of every 16 cycles.
